// File: rtl/register_file_param.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_param
//  Description : Parametrised datapath register file. DEPTH x WIDTH storage
//                with one write port, two registered read ports sharing a
//                read enable and output-valid flag, write-first bypass,
//                synchronous bulk clear, and a per-register written mask.
//                Optional build macro REGFILE_ZERO_REG_EN hardwires
//                register 0 to zero.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module register_file_param #(
  parameter int  WIDTH = 16,
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic [AW-1:0]    W1,
  input  logic [WIDTH-1:0] Din,
  input  logic             CLR,
  input  logic             RE,
  input  logic [AW-1:0]    num_R1,
  input  logic [AW-1:0]    num_R2,
  output logic [WIDTH-1:0] Dout_1,
  output logic [WIDTH-1:0] Dout_2,
  output logic             Dout_valid,
  output logic [DEPTH-1:0] Written
);

  // Upper bound used for range checks; one extra bit so that DEPTH itself
  // is representable when DEPTH is a power of two.
  localparam logic [AW:0] DEPTH_LIM = DEPTH[AW:0];

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  // Storage view assembled from the per-entry registers below
  logic [WIDTH-1:0] rf [DEPTH];
  logic [DEPTH-1:0] written_q;

  // Registered read results
  logic [WIDTH-1:0] dout_1_q;
  logic [WIDTH-1:0] dout_2_q;
  logic             dout_valid_q;

  // Address qualification
  logic             w1_in_range;
  logic             r1_in_range;
  logic             r2_in_range;
  logic             w1_is_zero_reg;
  logic             r1_is_zero_reg;
  logic             r2_is_zero_reg;

  // Effective write strobe and its one-hot decode
  logic             wr_en;
  logic [DEPTH-1:0] wr_sel;

  // Next read data for each port, bypass and clear already applied
  logic [WIDTH-1:0] rd_1;
  logic [WIDTH-1:0] rd_2;

  assign w1_in_range = ({1'b0, W1}     < DEPTH_LIM);
  assign r1_in_range = ({1'b0, num_R1} < DEPTH_LIM);
  assign r2_in_range = ({1'b0, num_R2} < DEPTH_LIM);

  // With the zero register enabled, index 0 is neither writable nor
  // readable; it behaves as a constant zero source.
  assign w1_is_zero_reg = ZERO_REG && (W1     == '0);
  assign r1_is_zero_reg = ZERO_REG && (num_R1 == '0);
  assign r2_is_zero_reg = ZERO_REG && (num_R2 == '0);

  // Clear wins over a concurrent write, so the write is dropped entirely.
  assign wr_en = WE && !CLR && w1_in_range && !w1_is_zero_reg;

  // One-hot write select derived from the qualified write strobe
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_sel[i] = wr_en && (W1 == AW'(i));
    end
  end

  // Each entry is an independent register with its own written flag
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic [WIDTH-1:0] data_q;
      logic             wr_flag_q;

      // Entry storage: reset/clear to zero, load on its write select
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          data_q    <= '0;
          wr_flag_q <= 1'b0;
        end else if (CLR) begin
          data_q    <= '0;
          wr_flag_q <= 1'b0;
        end else if (wr_sel[i]) begin
          data_q    <= Din;
          wr_flag_q <= 1'b1;
        end
      end

      assign rf[i]        = data_q;
      assign written_q[i] = wr_flag_q;
    end
  endgenerate

  // Port 1 read mux: zero when clearing, out of range or zero register;
  // otherwise write-first bypass of same-edge data, else stored value.
  always_comb begin
    rd_1 = '0;
    if (!CLR && r1_in_range && !r1_is_zero_reg) begin
      if (wr_en && (W1 == num_R1)) begin
        rd_1 = Din;
      end else begin
        rd_1 = rf[num_R1];
      end
    end
  end

  // Port 2 read mux, identical policy to port 1
  always_comb begin
    rd_2 = '0;
    if (!CLR && r2_in_range && !r2_is_zero_reg) begin
      if (wr_en && (W1 == num_R2)) begin
        rd_2 = Din;
      end else begin
        rd_2 = rf[num_R2];
      end
    end
  end

  // Output registers: capture on RE, otherwise hold; valid mirrors RE
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout_1_q     <= '0;
      dout_2_q     <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= RE;
      if (RE) begin
        dout_1_q <= rd_1;
        dout_2_q <= rd_2;
      end
    end
  end

  assign Dout_1     = dout_1_q;
  assign Dout_2     = dout_2_q;
  assign Dout_valid = dout_valid_q;
  assign Written    = written_q;

endmodule
`default_nettype wire

// File: tb/tb_register_file_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_param
//  Description : Self-checking bench for register_file_param. Drives a
//                default 16x8 instance against a scoreboard model and a
//                32x5 instance for the parametrised/zero-register cases.
//                Expectations follow REGFILE_ZERO_REG_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_param;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] d1;
    logic [15:0] d2;
    logic        v;
    logic [7:0]  wr;
  } obs_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;

  // 16x8 instance signals
  logic        WE = 0, CLR = 0, RE = 0;
  logic [2:0]  W1 = 0, num_R1 = 0, num_R2 = 0;
  logic [15:0] Din = 0;
  logic [15:0] Dout_1, Dout_2;
  logic        Dout_valid;
  logic [7:0]  Written;

  // 32x5 instance signals
  logic        P_WE = 0, P_CLR = 0, P_RE = 0;
  logic [2:0]  P_W1 = 0, P_R1 = 0, P_R2 = 0;
  logic [31:0] P_Din = 0;
  logic [31:0] P_Dout_1, P_Dout_2;
  logic        P_Dout_valid;
  logic [4:0]  P_Written;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model state
  logic [15:0] m_rf [8];
  logic [7:0]  m_wr = 0;
  logic [15:0] m_d1 = 0, m_d2 = 0;
  logic        m_v  = 0;

  obs_t sb  [$];
  obs_t obs [$];

  register_file_param #(.WIDTH(16), .DEPTH(8)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .W1(W1), .Din(Din), .CLR(CLR), .RE(RE),
    .num_R1(num_R1), .num_R2(num_R2), .Dout_1(Dout_1), .Dout_2(Dout_2),
    .Dout_valid(Dout_valid), .Written(Written)
  );

  register_file_param #(.WIDTH(32), .DEPTH(5)) dut5 (
    .CLK(CLK), .RST(RST), .WE(P_WE), .W1(P_W1), .Din(P_Din), .CLR(P_CLR),
    .RE(P_RE), .num_R1(P_R1), .num_R2(P_R2), .Dout_1(P_Dout_1),
    .Dout_2(P_Dout_2), .Dout_valid(P_Dout_valid), .Written(P_Written)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] model_read(input logic [2:0] idx,
      input logic we, input logic [2:0] w1, input logic [15:0] din,
      input logic clr);
    if (clr || (ZR && idx == 3'd0)) return 16'h0;
    if (we && w1 == idx) return din;
    return m_rf[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
    m_wr = 0; m_d1 = 0; m_d2 = 0; m_v = 0;
  endtask

  // Apply one clock of stimulus, push the expected result, record observed
  task automatic drive_cycle(input logic we, input logic [2:0] w1,
      input logic [15:0] din, input logic clr, input logic re,
      input logic [2:0] r1, input logic [2:0] r2);
    obs_t e, o;
    WE = we; W1 = w1; Din = din; CLR = clr; RE = re; num_R1 = r1; num_R2 = r2;
    if (re) begin
      m_d1 = model_read(r1, we, w1, din, clr);
      m_d2 = model_read(r2, we, w1, din, clr);
    end
    m_v = re;
    if (clr) begin
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
      m_wr = 0;
    end else if (we && !(ZR && w1 == 3'd0)) begin
      m_rf[w1] = din;
      m_wr[w1] = 1'b1;
    end
    e = '{m_d1, m_d2, m_v, m_wr};
    sb.push_back(e);
    @(posedge CLK);
    #1;
    o = '{Dout_1, Dout_2, Dout_valid, Written};
    obs.push_back(o);
    WE = 0; CLR = 0; RE = 0;
  endtask

  task automatic test_reset();
    obs_t e, o;
    int k = 0;
    // Power-on reset state
    #3;
    n_run++;
    if ({Dout_1, Dout_2, Dout_valid, Written, P_Dout_1, P_Dout_2, P_Dout_valid, P_Written} !== '0) begin
      n_fail++;
      $display("FAIL reset_init: got d1=%h d2=%h v=%b wr=%b p_wr=%b, want all zero",
               Dout_1, Dout_2, Dout_valid, Written, P_Written);
    end
    #9 RST = 0;
    model_reset();
    drive_cycle(1, 3'd1, 16'h1234, 0, 0, 3'd0, 3'd0);
    drive_cycle(0, 3'd0, 16'h0, 0, 1, 3'd1, 3'd1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_pre[%0d]: got d1=%h d2=%h v=%b wr=%b, want d1=%h d2=%h v=%b wr=%b",
                 k, o.d1, o.d2, o.v, o.wr, e.d1, e.d2, e.v, e.wr);
      end
      k++;
    end
    // Mid-cycle asynchronous reset must clear outputs before any edge
    #2 RST = 1;
    #1;
    n_run++;
    if ({Dout_1, Dout_2, Dout_valid, Written} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got d1=%h d2=%h v=%b wr=%b, want all zero",
               Dout_1, Dout_2, Dout_valid, Written);
    end
    #1 RST = 0;
    model_reset();
    drive_cycle(0, 3'd0, 16'h0, 0, 1, 3'd1, 3'd0);
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_post[%0d]: got d1=%h d2=%h v=%b wr=%b, want d1=%h d2=%h v=%b wr=%b",
                 k, o.d1, o.d2, o.v, o.wr, e.d1, e.d2, e.v, e.wr);
      end
      k++;
    end
  endtask

  task automatic test_basic();
    obs_t e, o;
    int k = 0;
    drive_cycle(1, 3'd3, 16'hA5A5, 0, 0, 3'd0, 3'd0);
    drive_cycle(0, 3'd0, 16'h0,    0, 1, 3'd3, 3'd5);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL basic[%0d]: got d1=%h d2=%h v=%b wr=%b, want d1=%h d2=%h v=%b wr=%b",
                 k, o.d1, o.d2, o.v, o.wr, e.d1, e.d2, e.v, e.wr);
      end
      k++;
    end
  endtask

  task automatic test_bypass();
    obs_t e, o;
    int k = 0;
    drive_cycle(1, 3'd6, 16'h00FF, 0, 1, 3'd6, 3'd6);
    drive_cycle(1, 3'd5, 16'h5555, 0, 1, 3'd3, 3'd5);
    drive_cycle(1, 3'd2, 16'h2A2A, 0, 1, 3'd2, 3'd6);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL bypass[%0d]: got d1=%h d2=%h v=%b wr=%b, want d1=%h d2=%h v=%b wr=%b",
                 k, o.d1, o.d2, o.v, o.wr, e.d1, e.d2, e.v, e.wr);
      end
      k++;
    end
  endtask

  task automatic test_clear();
    obs_t e, o;
    int k = 0;
    drive_cycle(1, 3'd2, 16'h1111, 0, 0, 3'd0, 3'd0);
    drive_cycle(1, 3'd4, 16'h2222, 1, 1, 3'd2, 3'd4);
    drive_cycle(0, 3'd0, 16'h0,    0, 1, 3'd4, 3'd6);
    // Clear without a read leaves the output registers alone
    drive_cycle(1, 3'd7, 16'h7777, 0, 1, 3'd7, 3'd7);
    drive_cycle(0, 3'd0, 16'h0,    1, 0, 3'd0, 3'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL clear[%0d]: got d1=%h d2=%h v=%b wr=%b, want d1=%h d2=%h v=%b wr=%b",
                 k, o.d1, o.d2, o.v, o.wr, e.d1, e.d2, e.v, e.wr);
      end
      k++;
    end
  endtask

  task automatic test_hold();
    obs_t e, o;
    int k = 0;
    drive_cycle(1, 3'd1, 16'hBEEF, 0, 0, 3'd0, 3'd0);
    drive_cycle(0, 3'd0, 16'h0, 0, 1, 3'd1, 3'd0);
    for (int i = 0; i < 3; i++) drive_cycle(0, 3'd0, 16'h0, 0, 0, 3'd2, 3'd3);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL hold[%0d]: got d1=%h d2=%h v=%b wr=%b, want d1=%h d2=%h v=%b wr=%b",
                 k, o.d1, o.d2, o.v, o.wr, e.d1, e.d2, e.v, e.wr);
      end
      k++;
    end
  endtask

  task automatic test_zero_reg();
    obs_t e, o;
    int k = 0;
    drive_cycle(1, 3'd0, 16'h0BAD, 0, 1, 3'd0, 3'd1);
    drive_cycle(0, 3'd0, 16'h0,    0, 1, 3'd7, 3'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL zero_reg[%0d]: got d1=%h d2=%h v=%b wr=%b, want d1=%h d2=%h v=%b wr=%b",
                 k, o.d1, o.d2, o.v, o.wr, e.d1, e.d2, e.v, e.wr);
      end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    int k = 0;
    for (int i = 0; i < 60; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  16'($urandom), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)));
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_run++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got d1=%h d2=%h v=%b wr=%b, want d1=%h d2=%h v=%b wr=%b",
                 k, o.d1, o.d2, o.v, o.wr, e.d1, e.d2, e.v, e.wr);
      end
      k++;
    end
  endtask

  // 32x5 instance: out-of-range index and zero-register behaviour
  task automatic test_param();
    logic [31:0] x0   = ZR ? 32'h0 : 32'hDEADBEEF;
    logic [31:0] xb   = ZR ? 32'h0 : 32'hCAFEF00D;
    logic [4:0]  wr0  = ZR ? 5'b00000 : 5'b00001;
    logic [4:0]  wr4  = ZR ? 5'b10000 : 5'b10001;
    P_WE = 1; P_W1 = 3'd0; P_Din = 32'hDEADBEEF;
    @(posedge CLK); #1;
    P_W1 = 3'd7;
    @(posedge CLK); #1;
    n_run++;
    if (P_Written !== wr0) begin
      n_fail++;
      $display("FAIL param_oor_write: got wr=%b, want wr=%b", P_Written, wr0);
    end
    P_WE = 0; P_RE = 1; P_R1 = 3'd0; P_R2 = 3'd7;
    @(posedge CLK); #1;
    n_run++;
    if ({P_Dout_1, P_Dout_2, P_Dout_valid, P_Written} !== {x0, 32'h0, 1'b1, wr0}) begin
      n_fail++;
      $display("FAIL param_read0: got d1=%h d2=%h v=%b wr=%b, want d1=%h d2=0 v=1 wr=%b",
               P_Dout_1, P_Dout_2, P_Dout_valid, P_Written, x0, wr0);
    end
    P_WE = 1; P_W1 = 3'd4; P_Din = 32'h01234567; P_R1 = 3'd4; P_R2 = 3'd5;
    @(posedge CLK); #1;
    n_run++;
    if ({P_Dout_1, P_Dout_2, P_Dout_valid, P_Written} !== {32'h01234567, 32'h0, 1'b1, wr4}) begin
      n_fail++;
      $display("FAIL param_last: got d1=%h d2=%h v=%b wr=%b, want d1=01234567 d2=0 v=1 wr=%b",
               P_Dout_1, P_Dout_2, P_Dout_valid, P_Written, wr4);
    end
    P_W1 = 3'd0; P_Din = 32'hCAFEF00D; P_R1 = 3'd0; P_R2 = 3'd4;
    @(posedge CLK); #1;
    n_run++;
    if ({P_Dout_1, P_Dout_2, P_Dout_valid} !== {xb, 32'h01234567, 1'b1}) begin
      n_fail++;
      $display("FAIL param_bypass0: got d1=%h d2=%h v=%b, want d1=%h d2=01234567 v=1",
               P_Dout_1, P_Dout_2, P_Dout_valid, xb);
    end
    P_WE = 0; P_RE = 0;
    @(posedge CLK); #1;
    n_run++;
    if ({P_Dout_1, P_Dout_2, P_Dout_valid} !== {xb, 32'h01234567, 1'b0}) begin
      n_fail++;
      $display("FAIL param_hold: got d1=%h d2=%h v=%b, want d1=%h d2=01234567 v=0",
               P_Dout_1, P_Dout_2, P_Dout_valid, xb);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_clear();
    test_hold();
    test_zero_reg();
    test_back_to_back();
    test_param();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/register_file_param.md
Name: register_file_param

Overview:
- Parametrised successor to the fixed 8x16 datapath register file.
- Holds DEPTH registers of WIDTH bits, with one write port and two registered read ports feeding the ALU.
- Adds to the previous generation:
  - read enable with an output-valid flag
  - write-to-read bypass
  - synchronous bulk clear
  - per-register "written" tracking mask, used by the controller to detect reads of uninitialised registers

Parameters:
WIDTH, 16, data width of each register and of Din/Dout_1/Dout_2
DEPTH, 8, number of registers; must be >= 2; need not be a power of two
AW, $clog2(DEPTH), address width (localparam, derived, not overridable)

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  asynchronous reset, active-high
WE  input  1  write enable
W1  input  AW  register index to write
Din  input  WIDTH  write data
CLR  input  1  synchronous clear of all registers and the written mask
RE  input  1  read enable for both read ports
num_R1  input  AW  read index, port 1
num_R2  input  AW  read index, port 2
Dout_1  output  WIDTH  registered read data, port 1
Dout_2  output  WIDTH  registered read data, port 2
Dout_valid  output  1  high for one cycle after each cycle with RE=1
Written  output  DEPTH  bit i set once register i has been written since the last reset/clear

Behaviour:
- Clock and reset: one clock (CLK); reset is asynchronous and active-high (RST). RST asserted forces, without waiting for a clock edge:
  - every RF entry = 0
  - Dout_1 = Dout_2 = 0
  - Dout_valid = 0
  - Written = 0
- RST deassertion is synchronised externally. The first edge after release is a normal edge.
- Write: on a rising edge with WE=1, CLR=0 and W1 < DEPTH:
  - RF[W1] <= Din
  - Written[W1] <= 1
- Out-of-range writes: W1 >= DEPTH (non-power-of-two DEPTH) is silently ignored and Written is unchanged.
- Read, one-cycle latency: on a rising edge with RE=1:
  - Dout_1 <= RF[num_R1] and Dout_2 <= RF[num_R2]
  - Dout_valid <= 1
- Read disabled: with RE=0, Dout_1/Dout_2 hold their previous values and Dout_valid <= 0.
- Out-of-range reads (index >= DEPTH) return 0.
- Bypass (write-first): if RE=1, WE=1, CLR=0 and W1 == num_Rx (in range) on the same edge, Dout_x <= Din rather than the stale RF value.
  - Both ports may bypass simultaneously.
  - num_R1 == num_R2 is legal; both ports return the same value.
- Clear: CLR=1 on a rising edge sets every RF entry to 0 and Written to 0.
  - CLR has priority over WE; a concurrent write is dropped.
  - A concurrent read (RE=1) returns 0 on both ports with Dout_valid=1.
  - Dout registers are not otherwise affected by CLR.
- Written is a pure register output, updated on the same edge as the RF write, with no combinational path from inputs.
- Reset mid-operation: any in-flight read result is discarded. Dout_valid drops to 0 immediately on RST assertion.

Optional Feature:
Macro: REGFILE_ZERO_REG_EN
- Defined: register 0 is hardwired to zero.
  - Writes with W1=0 are ignored and Written[0] stays 0.
  - Reads of index 0 always return 0, including when WE=1 and W1=0 on the same edge (no bypass for index 0).
  - CLR and RST behave as normal for all other entries.
- Not defined: register 0 is an ordinary storage register, identical to all other entries.

Test Plan:
1. Reset values: assert RST mid-cycle with Dout_1=16'h1234 -> Dout_1, Dout_2, Dout_valid and Written all read 0 immediately, before any CLK edge.
2. Basic write/read: write 16'hA5A5 to reg 3 (WE=1, W1=3), next cycle RE=1, num_R1=3, num_R2=5 -> following cycle Dout_1=16'hA5A5, Dout_2=0, Dout_valid=1, Written=8'b0000_1000.
3. Bypass: same edge WE=1, W1=6, Din=16'h00FF, RE=1, num_R1=6, num_R2=6 -> next cycle Dout_1=Dout_2=16'h00FF.
4. Clear priority: reg 2 holds 16'h1111; one edge with CLR=1, WE=1, W1=4, Din=16'h2222, RE=1, num_R1=2, num_R2=4 -> Dout_1=Dout_2=0, Dout_valid=1, Written=0; a later read of reg 4 returns 0.
5. Hold and valid: RE=1 for one edge reading 16'hBEEF, then RE=0 for 3 edges -> Dout_1 stays 16'hBEEF, Dout_valid is 1 for exactly one cycle then 0.
6. Parametrisation with REGFILE_ZERO_REG_EN: WIDTH=32, DEPTH=5, macro defined. Write 32'hDEADBEEF to reg 0 and to reg 7 (out of range), read both -> both return 0 and Written=5'b00000. Repeat the reg 0 case with the macro undefined -> reg 0 reads 32'hDEADBEEF and Written=5'b00001.
